// File: rtl/alu_pipe_hs.sv
// Handshaked, registered ALU: single-cycle logic/arith ops plus signed compare and equality.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (op 8); otherwise op 8 reports err.
module alu_pipe_hs #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             car,
  output logic             of,
  output logic             zero,
  output logic             err
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_NOT = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_EQ  = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef ALU_MUL_EN
    BUSY = 2'd1,
`endif
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] res_reg, res_hi_reg;
  logic             car_reg, of_reg, zero_reg, err_reg;

  logic             accept;
  logic             is_mul;

  logic [WIDTH:0]   sum_add, sum_sub;
  logic [WIDTH-1:0] alu_res;
  logic             alu_car, alu_of, alu_err;

  assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == DONE);

  assign res    = res_reg;
  assign res_hi = res_hi_reg;
  assign car    = car_reg;
  assign of     = of_reg;
  assign zero   = zero_reg;
  assign err    = err_reg;

  // Subtract is a + ~b + 1 so car=1 means no borrow.
  assign sum_add = {1'b0, a} + {1'b0, b};
  assign sum_sub = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

  always_comb begin
    alu_res = '0;
    alu_car = 1'b0;
    alu_of  = 1'b0;
    alu_err = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum_add[WIDTH-1:0];
        alu_car = sum_add[WIDTH];
        alu_of  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_add[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sum_sub[WIDTH-1:0];
        alu_car = sum_sub[WIDTH];
        alu_of  = (a[WIDTH-1] != b[WIDTH-1]) && (sum_sub[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NOT: alu_res = ~a;
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SLT: alu_res = WIDTH'($signed(a) < $signed(b));
      OP_EQ:  alu_res = WIDTH'(a == b);
      default: alu_err = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0]   mcand_reg;
  logic [CW-1:0]      count_reg;
  logic [WIDTH:0]     step_sum;
  logic               mul_last;

  assign is_mul = (op == OP_MUL);

  // Low half starts as the multiplier and shifts out one bit per step while the
  // partial product grows into the high half.
  assign step_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
  assign acc_next = {step_sum, acc_reg[WIDTH-1:1]};
  assign mul_last = (count_reg == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg   <= '0;
      mcand_reg <= '0;
      count_reg <= '0;
    end else if (accept && is_mul) begin
      acc_reg   <= {{WIDTH{1'b0}}, b};
      mcand_reg <= a;
      count_reg <= '0;
    end else if (state_reg == BUSY) begin
      acc_reg   <= acc_next;
      count_reg <= count_reg + CW'(1);
    end
  end
`else
  assign is_mul = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (accept) begin
`ifdef ALU_MUL_EN
          state_next = is_mul ? BUSY : DONE;
`else
          state_next = DONE;
`endif
        end else if ((state_reg == DONE) && out_ready) begin
          state_next = IDLE;
        end
      end
`ifdef ALU_MUL_EN
      BUSY: begin
        if (mul_last) state_next = DONE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      res_reg    <= '0;
      res_hi_reg <= '0;
      car_reg    <= 1'b0;
      of_reg     <= 1'b0;
      zero_reg   <= 1'b1;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept && !is_mul) begin
        res_reg    <= alu_err ? '0 : alu_res;
        res_hi_reg <= '0;
        car_reg    <= alu_car;
        of_reg     <= alu_of;
        zero_reg   <= alu_err || (alu_res == '0);
        err_reg    <= alu_err;
      end
`ifdef ALU_MUL_EN
      else if ((state_reg == BUSY) && mul_last) begin
        res_reg    <= acc_next[WIDTH-1:0];
        res_hi_reg <= acc_next[2*WIDTH-1:WIDTH];
        car_reg    <= 1'b0;
        of_reg     <= 1'b0;
        zero_reg   <= (acc_next == '0);
        err_reg    <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_pipe_hs.sv
// Self-checking bench for alu_pipe_hs (WIDTH=4): directed cases then randomized ops vs. an arithmetic model.
module tb_alu_pipe_hs;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] res, res_hi;
  logic         car, of, zero, err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_pipe_hs #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .res_hi(res_hi), .car(car), .of(of), .zero(zero), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected results from plain integer arithmetic on the operand values.
  task automatic model(input int o, input int ai, input int bi,
                       output int r, output int rh, output int c, output int v,
                       output int e, output int lat);
    int sa, sb, s;
    r = 0; rh = 0; c = 0; v = 0; e = 0; lat = 1;
    sa = (ai >= M/2) ? ai - M : ai;
    sb = (bi >= M/2) ? bi - M : bi;
    case (o)
      0: begin
        s = ai + bi; r = s % M; c = (s >= M) ? 1 : 0;
        v = ((sa + sb) > M/2 - 1 || (sa + sb) < -(M/2)) ? 1 : 0;
      end
      1: begin
        r = ((ai - bi) % M + M) % M; c = (ai >= bi) ? 1 : 0;
        v = ((sa - sb) > M/2 - 1 || (sa - sb) < -(M/2)) ? 1 : 0;
      end
      2: r = (M - 1) - ai;
      3: r = ai & bi;
      4: r = ai | bi;
      5: r = ai ^ bi;
      6: r = (sa < sb) ? 1 : 0;
      7: r = (ai == bi) ? 1 : 0;
`ifdef ALU_MUL_EN
      8: begin s = ai * bi; r = s % M; rh = s / M; lat = W + 1; end
`else
      8: e = 1;
`endif
      default: e = 1;
    endcase
  endtask

  task automatic run_op(input int o, input int ai, input int bi, input int stall);
    int er, erh, ec, ev, ee, el, lat;
    logic [W-1:0] held;
    model(o, ai, bi, er, erh, ec, ev, ee, el);
    @(negedge clk);
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; op = 4'(o); a = W'(ai); b = W'(bi);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid) check("in_ready_busy", in_ready, 0);
    end while (!out_valid && lat < 40);
    check($sformatf("lat op%0d", o), lat, el);
    check($sformatf("res op%0d a%0d b%0d", o, ai, bi), res, er);
    check($sformatf("res_hi op%0d", o), res_hi, erh);
    check($sformatf("car op%0d a%0d b%0d", o, ai, bi), car, ec);
    check($sformatf("of op%0d a%0d b%0d", o, ai, bi), of, ev);
    check($sformatf("zero op%0d", o), zero, (er == 0 && erh == 0) ? 1 : 0);
    check($sformatf("err op%0d", o), err, ee);
    $display("txn op=%0d a=%0d b=%0d res=%0d res_hi=%0d car=%0b of=%0b zero=%0b err=%0b lat=%0d",
             o, ai, bi, res, res_hi, car, of, zero, err, lat);
    if (stall > 0) begin
      held = res;
      out_ready = 1'b0;
      repeat (stall) begin
        @(negedge clk);
        check("stall_valid", out_valid, 1);
        check("stall_res", res, held);
        check("stall_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
    end
  endtask

  initial begin
    // Reset held with in_valid asserted must not capture anything.
    rst_n = 1'b0; in_valid = 1'b1; op = 4'd0; a = 4'd7; b = 4'd1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_zero", zero, 1);
    check("rst_res", res, 0);
    check("rst_err", err, 0);

    run_op(0, 7, 1, 0);
    check("add7_1_res", res, 8);
    check("add7_1_of", of, 1);
    run_op(0, 15, 1, 0);
    check("add15_1_car", car, 1);
    check("add15_1_zero", zero, 1);
    run_op(1, 8, 1, 0);
    check("sub8_1_res", res, 7);
    check("sub8_1_of", of, 1);
    run_op(6, 15, 1, 0);
    check("slt_m1_1", res, 1);
    run_op(7, 5, 5, 0);
    check("eq5_5", res, 1);
    run_op(8, 15, 15, 0);
`ifdef ALU_MUL_EN
    check("mul15_15_lo", res, 1);
    check("mul15_15_hi", res_hi, 14);
`else
    check("mul_off_err", err, 1);
`endif
    run_op(12, 9, 3, 0);
    check("illegal_err", err, 1);

    // Backpressure: result held while the next request waits.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; op = 4'd0; a = 4'd3; b = 4'd4;
    @(posedge clk);
    #1 op = 4'd5; a = 4'd12; b = 4'd10;
    repeat (3) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_res", res, 7);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_xor_valid", out_valid, 1);
    check("bp_xor_res", res, 6);
    $display("txn backpressure add 3+4 held, then xor 12^10 res=%0d", res);

`ifdef ALU_MUL_EN
    // Reset during the second BUSY cycle discards the multiply.
    @(negedge clk);
    in_valid = 1'b1; op = 4'd8; a = 4'd15; b = 4'd15;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_ready", in_ready, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_res", res, 0);
    check("abort_zero", zero, 1);
    repeat (6) begin
      @(negedge clk);
      check("abort_stays_idle", out_valid, 0);
    end
    $display("txn mul aborted by reset");
`endif

    for (int n = 0; n < 40; n++) begin
      int o;
      o = $urandom_range(0, 9);
      if (o == 9) o = $urandom_range(9, 15);
      run_op(o, $urandom_range(0, M - 1), $urandom_range(0, M - 1), $urandom_range(0, 2));
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
